// File: rtl/mkio_word_rx.sv
// mkio_word_rx: Manchester-coded word receiver (6 sync half-bits, DATA_W data bits, odd parity).
// Define MKIO_RX_GLITCH_FILTER_EN to insert a 3-sample majority filter after the synchronizer.
module mkio_word_rx #(
    parameter int HALF_BIT_CLKS = 16,
    parameter int DATA_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              di1,
    input  logic              di0,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_cmd,
    output logic              rx_valid,
    output logic              rx_err,
    output logic [1:0]        err_code,
    output logic              busy
);
    localparam int CNT_W    = $clog2(HALF_BIT_CLKS);
    localparam int TOTAL_HB = 2 * DATA_W + 8;
    localparam int HB_W     = $clog2(TOTAL_HB);

    localparam logic [CNT_W-1:0] SAMPLE_AT    = CNT_W'(HALF_BIT_CLKS / 2);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(HALF_BIT_CLKS - 1);
    localparam logic [HB_W-1:0]  HB_SYNC_LAST = HB_W'(5);
    localparam logic [HB_W-1:0]  HB_DATA_LAST = HB_W'(2 * DATA_W + 5);
    localparam logic [5:0]       SYNC_CMD     = 6'b111000;
    localparam logic [5:0]       SYNC_DATA    = 6'b000111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_PARITY,
        ST_DONE
    } state_t;

    // Line pair is carried as {di1, di0} through the input pipeline
    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] w_line;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {di1, di0};
            r_sync2 <= r_sync1;
        end
    end

`ifdef MKIO_RX_GLITCH_FILTER_EN
    localparam int PIPE_D = 4;

    logic [1:0] r_hist1;
    logic [1:0] r_hist2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hist1 <= '0;
            r_hist2 <= '0;
        end else begin
            r_hist1 <= r_sync2;
            r_hist2 <= r_hist1;
        end
    end

    assign w_line = (r_sync2 & r_hist1) | (r_sync2 & r_hist2) | (r_hist1 & r_hist2);
`else
    localparam int PIPE_D = 2;

    assign w_line = r_sync2;
`endif

    // Marks when every stage feeding w_line holds a real line sample rather than reset zeros
    logic [PIPE_D-1:0] r_vld;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[PIPE_D-2:0], 1'b1};
        end
    end

    logic w_di1;
    logic w_idle;
    logic w_pipe_ok;

    assign w_di1     = w_line[1];
    assign w_idle    = (w_line[1] == w_line[0]);
    assign w_pipe_ok = r_vld[PIPE_D-1];

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [HB_W-1:0]   r_hb;
    logic [4:0]        r_pat;
    logic              r_first;
    logic [DATA_W-1:0] r_shift;
    logic              r_par;
    logic              r_cmd_pend;
    logic              r_armed;
    logic [DATA_W-1:0] r_data;
    logic              r_cmd;
    logic              r_valid;
    logic              r_err;
    logic [1:0]        r_code;
    logic              r_busy;

    logic             w_sample;
    logic [CNT_W-1:0] w_cnt_next;
    logic [5:0]       w_pat;
    logic             w_pat_ok;
    logic             w_err_idle;
    logic             w_err_sync;
    logic             w_err_manch;
    logic             w_abort;
    logic [1:0]       w_abort_code;

    assign w_sample   = (r_cnt == SAMPLE_AT);
    assign w_cnt_next = (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
    assign w_pat      = {r_pat, w_di1};
    assign w_pat_ok   = (w_pat == SYNC_CMD) || (w_pat == SYNC_DATA);

    always_comb begin
        w_err_idle  = 1'b0;
        w_err_sync  = 1'b0;
        w_err_manch = 1'b0;
        if (w_sample) begin
            case (r_state)
                ST_SYNC: begin
                    if (w_idle) begin
                        w_err_idle = 1'b1;
                    end else if ((r_hb == HB_SYNC_LAST) && !w_pat_ok) begin
                        w_err_sync = 1'b1;
                    end
                end
                ST_DATA, ST_PARITY: begin
                    if (w_idle) begin
                        w_err_idle = 1'b1;
                    end else if (r_hb[0] && (w_di1 == r_first)) begin
                        // Second half of a pair must be the complement of the first
                        w_err_manch = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        w_abort      = w_err_idle | w_err_sync | w_err_manch;
        w_abort_code = w_err_sync ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_hb       <= '0;
            r_pat      <= '0;
            r_first    <= 1'b0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_cmd_pend <= 1'b0;
            r_armed    <= 1'b0;
            r_data     <= '0;
            r_cmd      <= 1'b0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_code     <= 2'b00;
            r_busy     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (r_state != ST_IDLE) begin
                r_cnt <= w_cnt_next;
            end
            // A start is only accepted after the line has been seen idle
            if (w_idle && w_pipe_ok) begin
                r_armed <= 1'b1;
            end

            if (w_abort) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_cnt   <= '0;
                r_err   <= 1'b1;
                r_code  <= w_abort_code;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_cnt <= '0;
                        if (r_armed && !w_idle) begin
                            r_state <= ST_SYNC;
                            r_busy  <= 1'b1;
                            r_cnt   <= CNT_W'(1);
                            r_hb    <= '0;
                            r_armed <= 1'b0;
                        end
                    end
                    ST_SYNC: begin
                        if (w_sample) begin
                            r_pat <= w_pat[4:0];
                            r_hb  <= r_hb + HB_W'(1);
                            if (r_hb == HB_SYNC_LAST) begin
                                r_cmd_pend <= (w_pat == SYNC_CMD);
                                r_par      <= 1'b0;
                                r_state    <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (w_sample) begin
                            r_hb <= r_hb + HB_W'(1);
                            if (!r_hb[0]) begin
                                r_first <= w_di1;
                            end else begin
                                r_shift <= {r_shift[DATA_W-2:0], r_first};
                                r_par   <= r_par ^ r_first;
                                if (r_hb == HB_DATA_LAST) begin
                                    r_state <= ST_PARITY;
                                end
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (w_sample) begin
                            if (!r_hb[0]) begin
                                r_first <= w_di1;
                                r_hb    <= r_hb + HB_W'(1);
                            end else begin
                                r_state <= ST_DONE;
                                r_hb    <= '0;
                                if (r_par ^ r_first) begin
                                    r_data  <= r_shift;
                                    r_cmd   <= r_cmd_pend;
                                    r_valid <= 1'b1;
                                    r_code  <= 2'b00;
                                end else begin
                                    r_err  <= 1'b1;
                                    r_code <= 2'b11;
                                end
                            end
                        end
                    end
                    ST_DONE: begin
                        // Sample phase keeps running: half-bit 0 of a contiguous word lands here
                        if (w_sample) begin
                            if (w_idle) begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                                r_cnt   <= '0;
                            end else begin
                                r_state <= ST_SYNC;
                                r_pat   <= {4'b0000, w_di1};
                                r_hb    <= HB_W'(1);
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign rx_data  = r_data;
    assign rx_cmd   = r_cmd;
    assign rx_valid = r_valid;
    assign rx_err   = r_err;
    assign err_code = r_code;
    assign busy     = r_busy;

endmodule

// File: tb/tb_mkio_word_rx.sv
// tb_mkio_word_rx: table-driven and hand-sequenced checks of mkio_word_rx with a pulse scoreboard.
module tb_mkio_word_rx;
    localparam int H  = 16;
    localparam int DW = 16;
`ifdef MKIO_RX_GLITCH_FILTER_EN
    localparam int FILT = 1;
`else
    localparam int FILT = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          di1 = 1'b0;
    logic          di0 = 1'b0;
    logic [DW-1:0] rx_data;
    logic          rx_cmd;
    logic          rx_valid;
    logic          rx_err;
    logic [1:0]    err_code;
    logic          busy;

    always #5 clk = ~clk;

    mkio_word_rx #(
        .HALF_BIT_CLKS(H),
        .DATA_W       (DW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .di1     (di1),
        .di0     (di0),
        .rx_data (rx_data),
        .rx_cmd  (rx_cmd),
        .rx_valid(rx_valid),
        .rx_err  (rx_err),
        .err_code(err_code),
        .busy    (busy)
    );

    typedef struct packed {
        logic        is_err;
        logic        cmd;
        logic [15:0] data;
        logic [1:0]  code;
    } exp_t;

    typedef struct {
        int          sync_kind;   // 0 command, 1 data, 2 bad (110000)
        logic [15:0] data;
        logic        par_flip;
        int          fault_hb;    // -1 none
        int          fault_kind;  // 0 non-complementary pair, 1 idle half-bit
        exp_t        exp;
        logic [15:0] data_after;
    } vec_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    exp_t sb[$];
    int   vtimes[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic exp_t ev(input logic [15:0] d, input logic c);
        exp_t e;
        e.is_err = 1'b0;
        e.cmd    = c;
        e.data   = d;
        e.code   = 2'b00;
        return e;
    endfunction

    function automatic exp_t ee(input logic [1:0] code);
        exp_t e;
        e.is_err = 1'b1;
        e.cmd    = 1'b0;
        e.data   = 16'h0000;
        e.code   = code;
        return e;
    endfunction

    // Scoreboard consumer: every output pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (rx_valid || rx_err) begin
            exp_t e;
            chk("pulse_exclusive", 32'(rx_valid & rx_err), 32'd0);
            if (sb.size() == 0) begin
                chk("pulse_expected", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk("pulse_kind", 32'(rx_err), 32'(e.is_err));
                if (e.is_err) begin
                    $display("rx err   code=%b at cycle %0d", err_code, cyc);
                    chk("err_code", 32'(err_code), 32'(e.code));
                end else begin
                    $display("rx valid cmd=%b data=%h at cycle %0d", rx_cmd, rx_data, cyc);
                    chk("rx_cmd", 32'(rx_cmd), 32'(e.cmd));
                    chk("rx_data", 32'(rx_data), 32'(e.data));
                    vtimes.push_back(cyc);
                end
            end
        end
    end

    task automatic send_hb(input logic v1, input logic v0);
        di1 = v1;
        di0 = v0;
        repeat (H) @(negedge clk);
    endtask

    task automatic send_idle(input int n);
        di1 = 1'b0;
        di0 = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_word(input int sync_kind, input logic [15:0] data, input logic par_flip,
                             input int fault_hb, input int fault_kind);
        logic [5:0]  sp;
        logic [39:0] line;
        logic        p;
        logic        v1;
        case (sync_kind)
            0:       sp = 6'b111000;
            1:       sp = 6'b000111;
            default: sp = 6'b110000;
        endcase
        p = ~(^data) ^ par_flip;
        for (int k = 0; k < 6; k++) line[39-k] = sp[5-k];
        for (int i = 0; i < 16; i++) begin
            line[33-2*i] = data[15-i];
            line[32-2*i] = ~data[15-i];
        end
        line[1] = p;
        line[0] = ~p;
        for (int k = 0; k < 40; k++) begin
            v1 = line[39-k];
            if (k == fault_hb && fault_kind == 1) begin
                send_hb(1'b0, 1'b0);
                return;
            end
            if (k == fault_hb && fault_kind == 0) v1 = line[40-k];
            send_hb(v1, ~v1);
        end
    endtask

    task automatic wait_drain(input int budget);
        int c;
        c = 0;
        while (sb.size() > 0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("scoreboard_drain", 32'(sb.size()), 32'd0);
    endtask

    vec_t vec[9];

    initial begin
        int   n;
        bit   seen;
        logic seen_busy;

        vec[0] = '{0, 16'h0847, 1'b0, -1, 0, ev(16'h0847, 1'b1), 16'h0847};
        vec[1] = '{1, 16'hA5A5, 1'b0, -1, 0, ev(16'hA5A5, 1'b0), 16'hA5A5};
        vec[2] = '{1, 16'hA5A5, 1'b1, -1, 0, ee(2'b11),          16'hA5A5};
        vec[3] = '{2, 16'h1234, 1'b0, -1, 0, ee(2'b01),          16'hA5A5};
        vec[4] = '{1, 16'h0000, 1'b0, -1, 0, ev(16'h0000, 1'b0), 16'h0000};
        vec[5] = '{1, 16'hFFFF, 1'b0, -1, 0, ev(16'hFFFF, 1'b0), 16'hFFFF};
        vec[6] = '{0, 16'h8001, 1'b0, -1, 0, ev(16'h8001, 1'b1), 16'h8001};
        vec[7] = '{1, 16'h3C3C, 1'b0, 13, 0, ee(2'b10),          16'h8001};
        vec[8] = '{0, 16'h5A5A, 1'b0, 20, 1, ee(2'b10),          16'h8001};

        // Reset state
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset_rx_data", 32'(rx_data), 32'd0);
        chk("reset_rx_cmd", 32'(rx_cmd), 32'd0);
        chk("reset_rx_valid", 32'(rx_valid), 32'd0);
        chk("reset_rx_err", 32'(rx_err), 32'd0);
        chk("reset_err_code", 32'(err_code), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        send_idle(10);

        // Table-driven words
        for (int i = 0; i < 9; i++) begin
            sb.push_back(vec[i].exp);
            send_word(vec[i].sync_kind, vec[i].data, vec[i].par_flip, vec[i].fault_hb, vec[i].fault_kind);
            send_idle(3 * H);
            wait_drain(200);
            chk("rx_data_after_word", 32'(rx_data), 32'(vec[i].data_after));
            chk("busy_after_word", 32'(busy), 32'd0);
        end

        // Sync error latency: rx_err one cycle after the half-bit 5 sample
        sb.push_back(ee(2'b01));
        n    = 0;
        seen = 1'b0;
        fork
            send_word(2, 16'h0F0F, 1'b0, -1, 0);
            begin
                for (int c = 0; c < 200 && !seen; c++) begin
                    @(posedge clk);
                    n++;
                    @(negedge clk);
                    if (rx_err) seen = 1'b1;
                end
                chk("sync_err_latency", 32'(n), 32'(91 + FILT));
                @(negedge clk);
                chk("busy_after_sync_err", 32'(busy), 32'd0);
            end
        join
        send_idle(3 * H);
        wait_drain(200);

        // Back-to-back words
        vtimes.delete();
        sb.push_back(ev(16'h0847, 1'b1));
        sb.push_back(ev(16'hA5A5, 1'b0));
        sb.push_back(ev(16'h0000, 1'b0));
        sb.push_back(ev(16'hFFFF, 1'b0));
        send_word(0, 16'h0847, 1'b0, -1, 0);
        send_word(1, 16'hA5A5, 1'b0, -1, 0);
        send_word(1, 16'h0000, 1'b0, -1, 0);
        send_word(1, 16'hFFFF, 1'b0, -1, 0);
        send_idle(6 * H);
        wait_drain(200);
        chk("contig_valid_count", 32'(vtimes.size()), 32'd4);
        if (vtimes.size() == 4) begin
            for (int i = 1; i < 4; i++) chk("contig_spacing", 32'(vtimes[i] - vtimes[i-1]), 32'd640);
        end
        chk("busy_after_contig", 32'(busy), 32'd0);

        // Reset pulse at data bit 8 of a word
        fork
            send_word(0, 16'h0847, 1'b0, -1, 0);
            begin
                repeat (2 + 22 * H + 8) @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                chk("midreset_rx_data", 32'(rx_data), 32'd0);
                chk("midreset_rx_cmd", 32'(rx_cmd), 32'd0);
                chk("midreset_rx_valid", 32'(rx_valid), 32'd0);
                chk("midreset_rx_err", 32'(rx_err), 32'd0);
                chk("midreset_err_code", 32'(err_code), 32'd0);
                chk("midreset_busy", 32'(busy), 32'd0);
            end
        join
        send_idle(3 * H);
        sb.push_back(ev(16'h1234, 1'b0));
        send_word(1, 16'h1234, 1'b0, -1, 0);
        send_idle(3 * H);
        wait_drain(200);
        chk("after_reset_word", 32'(rx_data), 32'h1234);

        // One-cycle pulse on an idle line
        send_idle(3 * H);
`ifdef MKIO_RX_GLITCH_FILTER_EN
        seen_busy = 1'b0;
        di1 = 1'b1;
        @(negedge clk);
        di1 = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (busy) seen_busy = 1'b1;
        end
        chk("glitch_busy", 32'(seen_busy), 32'd0);
`else
        seen_busy = 1'b0;
        sb.push_back(ee(2'b10));
        di1 = 1'b1;
        @(negedge clk);
        di1 = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (busy) seen_busy = 1'b1;
        end
        chk("glitch_started", 32'(seen_busy), 32'd1);
        wait_drain(100);
`endif
        send_idle(2 * H);
        chk("final_scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1);
    end

endmodule
